pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32: PC width in bits.
REQ-002 Parameter RESET_VEC, default 0: PC value loaded on reset (XLEN bits).
REQ-003 Parameter STEP, default 4: sequential increment in bytes; power of two, at least 1.
REQ-004 Parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, at least 2.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 trap_valid  in  1  trap/exception redirect request.
REQ-008 trap_pc  in  XLEN  trap target.
REQ-009 redirect_valid  in  1  branch/jump resolution redirect.
REQ-010 redirect_pc  in  XLEN  redirect target.
REQ-011 stall  in  1  freeze sequential advance.
REQ-012 fetch_ready  in  1  instruction memory accepts pc_out.
REQ-013 is_call  in  1  accepted fetch is a call; push return address.
REQ-014 is_ret  in  1  accepted fetch is a return; predict from RAS.
REQ-015 fetch_valid  out  1  pc_out is a valid fetch request.
REQ-016 pc_out  out  XLEN  current fetch PC (registered).
REQ-017 misaligned  out  1  pc_out not a multiple of STEP (combinational from pc_out).
REQ-018 ras_empty  out  1  RAS holds no entries.

Function
REQ-019 A fetch is accepted in a cycle when fetch_valid=1, fetch_ready=1 and stall=0.
REQ-020 Next-PC priority per cycle: trap_valid > redirect_valid > accepted fetch with is_ret and RAS non-empty > accepted fetch (pc_out+STEP) > hold.
REQ-021 Trap and redirect load their target the next cycle regardless of fetch_valid, fetch_ready or stall.
REQ-022 After a cycle with trap_valid or redirect_valid, fetch_valid is 0 for exactly one cycle (bubble) and pc_out already holds the new target during it.
REQ-023 Outside reset and the redirect bubble, fetch_valid is 1.
REQ-024 Sequential arithmetic is modulo 2^XLEN: pc_out = 2^XLEN - STEP advances to 0 with no flag.
REQ-025 is_call and is_ret are ignored unless the fetch is accepted and neither trap_valid nor redirect_valid is asserted.
REQ-026 Accepted is_call pushes pc_out+STEP; with the RAS full, the push overwrites the oldest entry and the count stays RAS_DEPTH.
REQ-027 Accepted is_ret with RAS non-empty sets next PC to the top entry and pops it.
REQ-028 Accepted is_ret with RAS empty causes no pop and a sequential advance.
REQ-029 is_call and is_ret together: the top entry is replaced by pc_out+STEP, the next PC is the old top, and the count is unchanged; with RAS empty, the pair is treated as a call only.
REQ-030 Trap and redirect leave RAS contents unchanged.
REQ-031 misaligned = OR of pc_out[log2(STEP)-1:0] (0 when STEP=1); misaligned targets are loaded unmodified.

Reset
REQ-032 While reset=1: pc_out=RESET_VEC, fetch_valid=0, RAS count=0, ras_empty=1; all inputs ignored.
REQ-033 In the first cycle after reset deasserts, fetch_valid=1 with pc_out=RESET_VEC.
REQ-034 Reset asserted mid-operation, including during a bubble or with a full RAS, takes priority over every other event in that cycle.

Structure
REQ-035 Package pc_pkg holds the XLEN, STEP, RESET_VEC and RAS_DEPTH defaults and the next-PC source enum {NPC_HOLD, NPC_SEQ, NPC_RAS, NPC_REDIRECT, NPC_TRAP}.
REQ-036 The return address stack is a sub-module pc_ras: circular buffer with top pointer and saturating count, supporting push, pop and replace.

Verification
REQ-037 Reset, then fetch_ready=1 for 3 cycles -> pc_out 0, 4, 8, 12; fetch_valid=1 from the first post-reset cycle.
REQ-038 At pc_out=0x100: redirect_valid=1, redirect_pc=0x200 and trap_valid=1, trap_pc=0x80 in the same cycle -> pc_out=0x80, fetch_valid=0 for one cycle, then 0x84 once accepted.
REQ-039 Accepted is_call at 0x10, redirect to 0x400, accepted is_ret at 0x400 -> pc_out=0x14, ras_empty=1.
REQ-040 RAS_DEPTH=4: five accepted calls at 0x0,0x4,...,0x10, then five accepted rets -> targets 0x14,0x10,0xC,0x8, then sequential on the fifth ret.
REQ-041 pc_out=0xFFFFFFFC, accepted fetch -> pc_out=0; stall=1 with fetch_ready=1 -> pc_out holds; redirect_pc=0x6 -> misaligned=1.
REQ-042 Reset asserted with RAS holding 3 entries and a bubble pending -> pc_out=RESET_VEC, fetch_valid=0, ras_empty=1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared defaults and the next-PC source encoding for the fetch PC generator.
package pc_pkg;

    localparam int unsigned         PC_XLEN      = 32;
    localparam int unsigned         PC_STEP      = 4;
    localparam int unsigned         PC_RAS_DEPTH = 4;
    localparam logic [PC_XLEN-1:0]  PC_RESET_VEC = 32'h0000_0000;

    typedef enum logic [2:0] {
        NPC_HOLD     = 3'd0,
        NPC_SEQ      = 3'd1,
        NPC_RAS      = 3'd2,
        NPC_REDIRECT = 3'd3,
        NPC_TRAP     = 3'd4
    } npc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and a saturating count.
// A push when full silently overwrites the oldest entry.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned XLEN  = PC_XLEN,
    parameter int unsigned DEPTH = PC_RAS_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            replace_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            wr_en_s;
    logic [PW-1:0]   wr_idx_s;

    // Pointer/count next state and the single write port.
    always_comb begin
        ptr_d    = ptr_q;
        count_d  = count_q;
        wr_en_s  = 1'b0;
        wr_idx_s = ptr_q;
        if (replace_i) begin
            wr_en_s  = 1'b1;
        end else if (push_i) begin
            ptr_d    = ptr_q + PW'(1);
            wr_en_s  = 1'b1;
            wr_idx_s = ptr_q + PW'(1);
            if (count_q != CW'(DEPTH)) begin
                count_d = count_q + CW'(1);
            end else begin
                count_d = count_q;
            end
        end else if (pop_i && (count_q != '0)) begin
            ptr_d   = ptr_q - PW'(1);
            count_d = count_q - CW'(1);
        end else begin
            ptr_d   = ptr_q;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (!reset && wr_en_s) begin
            mem_q[wr_idx_s] <= data_i;
        end
    end

    assign top_o   = mem_q[ptr_q];
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: trap/redirect steering, sequential advance, and
// return-address prediction through pc_ras.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned      XLEN      = PC_XLEN,
    parameter logic [XLEN-1:0]  RESET_VEC = XLEN'(PC_RESET_VEC),
    parameter int unsigned      STEP      = PC_STEP,
    parameter int unsigned      RAS_DEPTH = PC_RAS_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            is_call,
    input  logic            is_ret,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc_out,
    output logic            misaligned,
    output logic            ras_empty
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    npc_src_e        npc_src_s;
    logic            accept_s, ctl_s, call_s, ret_s;
    logic [XLEN-1:0] seq_pc_s, ras_top_s;
    logic            ras_empty_s;

    assign accept_s = valid_q & fetch_ready & ~stall;
    // Call/return hints only count on a fetch that is not being squashed.
    assign ctl_s    = accept_s & ~trap_valid & ~redirect_valid;
    assign call_s   = ctl_s & is_call;
    assign ret_s    = ctl_s & is_ret & ~ras_empty_s;
    assign seq_pc_s = pc_q + XLEN'(STEP);

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push_i    (call_s & ~ret_s),
        .pop_i     (ret_s & ~call_s),
        .replace_i (call_s & ret_s),
        .data_i    (seq_pc_s),
        .top_o     (ras_top_s),
        .empty_o   (ras_empty_s)
    );

    // Next-PC source selection and next state.
    always_comb begin
        npc_src_s = NPC_HOLD;
        pc_d      = pc_q;
        valid_d   = ~(trap_valid | redirect_valid);
        if (trap_valid) begin
            npc_src_s = NPC_TRAP;
        end else if (redirect_valid) begin
            npc_src_s = NPC_REDIRECT;
        end else if (ret_s) begin
            npc_src_s = NPC_RAS;
        end else if (accept_s) begin
            npc_src_s = NPC_SEQ;
        end else begin
            npc_src_s = NPC_HOLD;
        end
        case (npc_src_s)
            NPC_TRAP:     pc_d = trap_pc;
            NPC_REDIRECT: pc_d = redirect_pc;
            NPC_RAS:      pc_d = ras_top_s;
            NPC_SEQ:      pc_d = seq_pc_s;
            NPC_HOLD:     pc_d = pc_q;
            default:      pc_d = pc_q;
        endcase
    end

    // PC and valid registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign pc_out      = pc_q;
    assign fetch_valid = valid_q;
    assign ras_empty   = ras_empty_s;
    assign misaligned  = ((pc_q & XLEN'(STEP - 1)) != '0);

endmodule
